ctl_score_bcd: RTL and testbench
================================

CTL_SCORE_BCD -- requirements
Module: ctl_score_bcd

Interface
REQ-001 Parameter NUM_DIGITS, default 2: BCD digits per score, legal range 1..8.
REQ-002 Parameter NUM_PLAYERS, default 1: independent score channels, legal range 1..4.
REQ-003 Parameter PSEL_W, default 2: player_sel width; SHALL be at least clog2(NUM_PLAYERS), minimum 1.
REQ-004 clk  in  1: single system clock, all logic on posedge.
REQ-005 rst  in  1: synchronous, active-high reset.
REQ-006 reset_score  in  1: synchronous clear of all scores (game restart); high-score register untouched.
REQ-007 hit  in  1: shot-landed level; scoring on rising edge only.
REQ-008 duck_hit  in  1: duck already hit / scoring blocked; when high, hit edges are ignored.
REQ-009 points  in  4: points per hit, binary; values 10..15 clamp to 9.
REQ-010 player_sel  in  PSEL_W: channel credited by a hit and shown on score_bcd.
REQ-011 score_bcd  out  NUM_DIGITS*4: selected player's score, digit 0 (units) in bits [3:0], registered.
REQ-012 high_score_bcd  out  NUM_DIGITS*4: best score since rst, registered (HIGH_SCORE_EN only).
REQ-013 score_sat  out  1: registered; high while the selected player's score equals all-9s.

Function
REQ-014 Edge detect: hit_last register; valid event = hit & ~hit_last & ~duck_hit, evaluated each cycle.
REQ-015 On valid event, score[player_sel] SHALL update at the next posedge to score + clamp(points), computed as a per-digit BCD add with decimal carry ripple in one cycle.
REQ-016 Latency: hit rising at posedge n SHALL appear on score_bcd after posedge n+2, giving 1 cycle for the counter and 1 for the output register.
REQ-017 Saturation: if the BCD sum carries out of the top digit, score SHALL clamp to all-9s; it never wraps.
REQ-018 points = 0 on a valid event: score unchanged, no error.
REQ-019 player_sel >= NUM_PLAYERS on a valid event: event dropped, no score changes; score_bcd shows all zeros.
REQ-020 Unselected players' scores SHALL hold.
REQ-021 hit held high SHALL score once; a new rising edge is needed for each point award.
REQ-022 reset_score with a valid event in the same cycle: reset_score wins, and all scores and hit_last go to 0.
REQ-023 Changing player_sel SHALL change score_bcd and score_sat one cycle later, with no effect on stored scores.
REQ-024 Every stored digit SHALL always be in 0..9.

Reset
REQ-025 rst SHALL clear all scores, hit_last, score_bcd, high_score_bcd and score_sat to 0.
REQ-026 reset_score SHALL clear scores, hit_last, score_bcd and score_sat, and SHALL NOT clear high_score_bcd.
REQ-027 rst asserted mid-operation SHALL take effect at the next posedge with no partial update; the first valid event after release requires a fresh hit rising edge.

Configuration
REQ-028 Macro CTL_SCORE_HIGH_SCORE_EN: when defined, a high-score register SHALL load any player's updated score whose BCD magnitude exceeds it, one cycle after the score update, and drive high_score_bcd.
REQ-029 When not defined, no high-score register SHALL be built and high_score_bcd SHALL be tied to 0.

Structure
REQ-030 Package ctl_score_pkg SHALL hold DIGIT_W=4, typedef bcd_digit_t (logic [3:0]), BCD_MAX_DIGIT=9, and function clamp_points.
REQ-031 Sub-module bcd_digit_add (a + b + cin -> sum 0..9, cout) SHALL be instantiated NUM_DIGITS times as the carry chain.
REQ-032 Scores SHALL be stored as NUM_PLAYERS x NUM_DIGITS bcd_digit_t registers; no binary-to-decimal division.

Verification
REQ-033 Defaults: rst, then 3 hit pulses with points=1, duck_hit=0 -> score_bcd=8'h03 two cycles after the last edge.
REQ-034 Score 8'h97, hit with points=5 -> 8'h99 and score_sat=1; a further hit -> stays 8'h99.
REQ-035 Score 8'h19, points=12 (clamped to 9) -> 8'h28, checking the decimal carry.
REQ-036 hit held high for 10 cycles -> +1 only; duck_hit=1 during a rising edge -> no change.
REQ-037 NUM_PLAYERS=2: P0=05 and P1=12 via player_sel; reset_score plus a hit in the same cycle -> both 00; with the macro on, high_score_bcd=8'h12 survives.
REQ-038 NUM_DIGITS=4: score 16'h0999 + 1 -> 16'h1000; rst mid-stream -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/ctl_score_pkg.sv
// Shared BCD types and helpers for the ctl_score_bcd score counter.
package ctl_score_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    // Award values above a single decimal digit saturate to 9 points.
    function automatic bcd_digit_t clamp_points(input logic [3:0] points);
        return (points > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : bcd_digit_t'(points);
    endfunction

endpackage

// File: rtl/ctl_score_bcd_digit_add.sv
// One decimal digit of the score adder: a + b + cin -> sum in 0..9 plus decimal carry.
module bcd_digit_add
    import ctl_score_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout
);

    logic [DIGIT_W:0] raw;

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
        sum  = raw[DIGIT_W-1:0];
        cout = 1'b0;
        if (raw > 5'd9) begin
            sum  = bcd_digit_t'(raw - 5'd10);
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/ctl_score_bcd.sv
// Per-player BCD score counter with hit edge detection, saturation and selectable display.
// Optional high-score register enabled by defining CTL_SCORE_HIGH_SCORE_EN.
module ctl_score_bcd
    import ctl_score_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int NUM_PLAYERS = 1,
    parameter int PSEL_W      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          reset_score,
    input  logic                          hit,
    input  logic                          duck_hit,
    input  logic [3:0]                    points,
    input  logic [PSEL_W-1:0]             player_sel,
    output logic [NUM_DIGITS*DIGIT_W-1:0] score_bcd,
    output logic [NUM_DIGITS*DIGIT_W-1:0] high_score_bcd,
    output logic                          score_sat
);

    typedef bcd_digit_t [NUM_DIGITS-1:0] score_t;

    localparam score_t ALL_NINES = {NUM_DIGITS{BCD_MAX_DIGIT}};

    score_t              score_q [NUM_PLAYERS];
    logic                hit_last;
    logic                valid_event;
    logic                sel_valid;
    score_t              sel_score;
    score_t              sum_digits;
    score_t              score_next;
    logic [NUM_DIGITS:0] carry;

    // Out-of-range selections match no player: nothing is credited and zero is shown.
    always_comb begin
        sel_valid = 1'b0;
        sel_score = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (player_sel == PSEL_W'(p)) begin
                sel_valid = 1'b1;
                sel_score = score_q[p];
            end
        end
    end

    assign valid_event = hit & ~hit_last & ~duck_hit;

    assign carry[0] = 1'b0;

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        bcd_digit_t addend;
        if (d == 0) begin : g_units
            assign addend = clamp_points(points);
        end else begin : g_upper
            assign addend = '0;
        end

        bcd_digit_add u_add (
            .a    (sel_score[d]),
            .b    (addend),
            .cin  (carry[d]),
            .sum  (sum_digits[d]),
            .cout (carry[d+1])
        );
    end

    // A carry out of the top digit means the score overflowed: pin it at all nines.
    assign score_next = carry[NUM_DIGITS] ? ALL_NINES : sum_digits;

    // NOTE: the score array is reset explicitly because both rst and a game
    // restart must zero every player, so it cannot be left as an unreset RAM.
    always_ff @(posedge clk) begin
        if (rst || reset_score) begin
            hit_last <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                score_q[p] <= '0;
            end
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            hit_last <= hit;
            if (valid_event) begin
                for (int p = 0; p < NUM_PLAYERS; p++) begin
                    if (player_sel == PSEL_W'(p)) begin
                        score_q[p] <= score_next;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || reset_score) begin
            score_bcd <= '0;
            score_sat <= 1'b0;
        end else begin
            score_bcd <= sel_score;
            score_sat <= sel_valid && (sel_score == ALL_NINES);
        end
    end

`ifdef CTL_SCORE_HIGH_SCORE_EN
    score_t best_now;
    score_t high_q;

    // Digits never exceed 9, so plain unsigned compare of packed BCD orders by magnitude.
    always_comb begin
        best_now = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (score_q[p] > best_now) begin
                best_now = score_q[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            high_q <= '0;
        end else if (best_now > high_q) begin
            high_q <= best_now;
        end
    end

    assign high_score_bcd = high_q;
`else
    assign high_score_bcd = '0;
`endif

endmodule

// File: tb/tb_ctl_score_bcd.sv
// Self-checking bench for ctl_score_bcd: a 2-digit/1-player and a 4-digit/3-player
// instance share stimulus and are compared against an integer score model.
module tb_ctl_score_bcd;

`ifdef CTL_SCORE_HIGH_SCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        reset_score;
    logic        hit;
    logic        duck_hit;
    logic [3:0]  points;
    logic [1:0]  player_sel;

    logic [7:0]  score_a;
    logic [7:0]  hi_a;
    logic        sat_a;
    logic [15:0] score_b;
    logic [15:0] hi_b;
    logic        sat_b;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain integer scores per player.
    int sc_a;
    int sc_b [3];
    int hi_a_m;
    int hi_b_m;
    bit hl_m;

    always #5 clk = ~clk;

    ctl_score_bcd #(.NUM_DIGITS(2), .NUM_PLAYERS(1), .PSEL_W(2)) dut_a (
        .clk            (clk),
        .rst            (rst),
        .reset_score    (reset_score),
        .hit            (hit),
        .duck_hit       (duck_hit),
        .points         (points),
        .player_sel     (player_sel),
        .score_bcd      (score_a),
        .high_score_bcd (hi_a),
        .score_sat      (sat_a)
    );

    ctl_score_bcd #(.NUM_DIGITS(4), .NUM_PLAYERS(3), .PSEL_W(2)) dut_b (
        .clk            (clk),
        .rst            (rst),
        .reset_score    (reset_score),
        .hit            (hit),
        .duck_hit       (duck_hit),
        .points         (points),
        .player_sel     (player_sel),
        .score_bcd      (score_b),
        .high_score_bcd (hi_b),
        .score_sat      (sat_b)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          x;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock: predict registered outputs from pre-edge model state,
    // update the model with this cycle's inputs, then compare after the edge.
    task automatic step();
        logic [15:0] e_sa, e_sb, e_ha, e_hb;
        logic        e_ta, e_tb;
        int          add;
        e_sa = '0; e_sb = '0; e_ta = 1'b0; e_tb = 1'b0;
        if (!(rst || reset_score)) begin
            if (player_sel == 2'd0) begin
                e_sa = to_bcd(sc_a);
                e_ta = (sc_a == 99);
            end
            if (player_sel < 2'd3) begin
                e_sb = to_bcd(sc_b[player_sel]);
                e_tb = (sc_b[player_sel] == 9999);
            end
        end
        if (rst) begin
            hi_a_m = 0;
            hi_b_m = 0;
        end else if (HS_EN) begin
            hi_a_m = max_i(hi_a_m, sc_a);
            for (int p = 0; p < 3; p++) hi_b_m = max_i(hi_b_m, sc_b[p]);
        end
        add = (points > 4'd9) ? 9 : int'(points);
        if (rst || reset_score) begin
            sc_a = 0;
            for (int p = 0; p < 3; p++) sc_b[p] = 0;
            hl_m = 1'b0;
        end else begin
            if (hit && !hl_m && !duck_hit) begin
                if (player_sel == 2'd0) sc_a = min_i(sc_a + add, 99);
                if (player_sel < 2'd3) sc_b[player_sel] = min_i(sc_b[player_sel] + add, 9999);
            end
            hl_m = hit;
        end
        e_ha = to_bcd(hi_a_m);
        e_hb = to_bcd(hi_b_m);
        @(posedge clk);
        #1;
        check("score_a", {8'h00, score_a}, {8'h00, e_sa[7:0]});
        check("sat_a", {15'h0, sat_a}, {15'h0, e_ta});
        check("high_a", {8'h00, hi_a}, {8'h00, e_ha[7:0]});
        check("score_b", score_b, e_sb);
        check("sat_b", {15'h0, sat_b}, {15'h0, e_tb});
        check("high_b", hi_b, e_hb);
    endtask

    task automatic pulse(input logic [3:0] pts, input logic [1:0] sel);
        points     = pts;
        player_sel = sel;
        hit        = 1'b1;
        step();
        hit        = 1'b0;
        step();
    endtask

    initial begin
        sc_a = 0; hi_a_m = 0; hi_b_m = 0; hl_m = 1'b0;
        for (int p = 0; p < 3; p++) sc_b[p] = 0;
        rst = 1'b1; reset_score = 1'b0; hit = 1'b0; duck_hit = 1'b0;
        points = 4'd0; player_sel = 2'd0;

        // Reset state
        step();
        step();
        check("rst_score_a", {8'h00, score_a}, 16'h0000);
        check("rst_score_b", score_b, 16'h0000);
        rst = 1'b0;
        step();

        // Three single-point hits
        for (int i = 0; i < 3; i++) pulse(4'd1, 2'd0);
        check("three_hits", {8'h00, score_a}, 16'h0003);

        // Climb to 97, then saturate
        for (int i = 0; i < 10; i++) pulse(4'd9, 2'd0);
        pulse(4'd4, 2'd0);
        check("at_97", {8'h00, score_a}, 16'h0097);
        pulse(4'd5, 2'd0);
        check("sat_99", {8'h00, score_a}, 16'h0099);
        check("sat_flag", {15'h0, sat_a}, 16'h0001);
        pulse(4'd1, 2'd0);
        check("stay_99", {8'h00, score_a}, 16'h0099);

        // Game restart, then decimal carry with clamped points
        reset_score = 1'b1;
        step();
        reset_score = 1'b0;
        step();
        check("restart", {8'h00, score_a}, 16'h0000);
        pulse(4'd9, 2'd0);
        pulse(4'd9, 2'd0);
        pulse(4'd1, 2'd0);
        check("at_19", {8'h00, score_a}, 16'h0019);
        pulse(4'd12, 2'd0);
        check("clamp_carry", {8'h00, score_a}, 16'h0028);
        pulse(4'd0, 2'd0);
        check("zero_points", {8'h00, score_a}, 16'h0028);

        // Held hit scores once; duck blocks a rising edge
        points = 4'd1;
        hit    = 1'b1;
        for (int i = 0; i < 10; i++) step();
        hit = 1'b0;
        step();
        check("held_hit", {8'h00, score_a}, 16'h0029);
        duck_hit = 1'b1;
        hit      = 1'b1;
        step();
        duck_hit = 1'b0;
        step();
        step();
        hit = 1'b0;
        step();
        check("duck_block", {8'h00, score_a}, 16'h0029);

        // Two players, then restart together with a hit
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        pulse(4'd5, 2'd0);
        pulse(4'd9, 2'd1);
        pulse(4'd3, 2'd1);
        check("p1_12", score_b, 16'h0012);
        player_sel = 2'd0;
        step();
        check("p0_05", score_b, 16'h0005);
        pulse(4'd2, 2'd3);
        check("sel_oob", score_b, 16'h0000);
        player_sel  = 2'd0;
        points      = 4'd1;
        hit         = 1'b1;
        reset_score = 1'b1;
        step();
        reset_score = 1'b0;
        hit         = 1'b0;
        step();
        check("restart_p0", score_b, 16'h0000);
        player_sel = 2'd1;
        step();
        check("restart_p1", score_b, 16'h0000);
        check("high_kept", hi_b, HS_EN ? 16'h0012 : 16'h0000);

        // Four-digit ripple 0999 -> 1000
        for (int i = 0; i < 111; i++) pulse(4'd9, 2'd0);
        check("at_0999", score_b, 16'h0999);
        pulse(4'd1, 2'd0);
        check("ripple_1000", score_b, 16'h1000);

        // rst mid-stream together with a rising hit
        points = 4'd7;
        hit    = 1'b1;
        rst    = 1'b1;
        step();
        check("midrst_score", score_b, 16'h0000);
        check("midrst_high", hi_b, 16'h0000);
        rst = 1'b0;
        hit = 1'b0;
        step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            hit         = 1'($urandom_range(0, 1));
            duck_hit    = ($urandom_range(0, 3) == 0);
            points      = 4'($urandom_range(0, 15));
            player_sel  = 2'($urandom_range(0, 3));
            reset_score = ($urandom_range(0, 59) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
